serial_sub: RTL



---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/serial_sub_sub_digit.sv | 25 ++
 rtl/serial_sub.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM state type and sizing helper for serial_sub
package serial_sub_pkg;

    // Operation phases: waiting for operands, digit-serial compute, result held
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Digit counter width: enough bits to count 0..n-1, never narrower than 1
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_sub_sub_digit.sv
// rtl/serial_sub_sub_digit.sv - combinational W-bit ripple subtractor from one-bit full-subtractor cells
module sub_digit #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    // Borrow chain: w_borrow[i] enters cell i, w_borrow[W] leaves the digit
    logic [W:0] w_borrow;

    assign w_borrow[0] = bin;

    for (genvar i = 0; i < W; i++) begin : g_cell
        // One-bit full subtractor: d = a ^ b ^ c, borrow when a < b + c
        assign diff[i]       = a[i] ^ b[i] ^ w_borrow[i];
        assign w_borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
    end

    assign bout = w_borrow[W];

endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - digit-serial A - B - bin subtractor with valid/ready handshakes (option: SERIAL_SUB_SIGNED_OVF_EN)
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [DIGIT-1:0] w_dig_diff;
    logic             w_dig_bout;
    logic [WIDTH-1:0] w_diff_shift;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign diff      = r_diff;
    assign bout      = r_bout;

    assign w_accept  = in_ready & in_valid;
    assign w_run     = (r_state == ST_RUN);
    assign w_last    = w_run && (r_cnt == LAST_CNT);

    // Low digit of each operand shift register, chained through the registered borrow
    sub_digit #(
        .W(DIGIT)
    ) u_sub_digit (
        .a   (r_a_sh[DIGIT-1:0]),
        .b   (r_b_sh[DIGIT-1:0]),
        .bin (r_borrow),
        .diff(w_dig_diff),
        .bout(w_dig_bout)
    );

    // New digit enters at the top so the first (least significant) digit lands at bit 0 after N shifts
    if (DIGIT == WIDTH) begin : g_diff_single
        assign w_diff_shift = w_dig_diff;
    end else begin : g_diff_multi
        assign w_diff_shift = {w_dig_diff, r_diff[WIDTH-1:DIGIT]};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; clr overrides every transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_next = ST_RUN;
            ST_RUN:  if (w_last)    w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
        if (clr) begin
            w_next = ST_IDLE;
        end
    end

    // Operand capture at accept, then one digit per cycle while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_cnt    <= '0;
        end else if (clr) begin
            r_bout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
        end else if (w_run) begin
            r_a_sh   <= r_a_sh >> DIGIT;
            r_b_sh   <= r_b_sh >> DIGIT;
            r_diff   <= w_diff_shift;
            r_borrow <= w_dig_bout;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_bout <= w_dig_bout;
            end
        end
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic r_a_sign;
    logic r_b_sign;
    logic r_ovf;

    assign ovf = r_ovf;

    // Sign bits captured at accept; overflow when signs differ and the result sign departs from a
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sign <= 1'b0;
            r_b_sign <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (clr) begin
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a_sign <= a[WIDTH-1];
            r_b_sign <= b[WIDTH-1];
        end else if (w_last) begin
            r_ovf    <= (r_a_sign ^ r_b_sign) & (w_diff_shift[WIDTH-1] ^ r_a_sign);
        end
    end
`endif

endmodule
